// File: rtl/rx_rate_monitor_if.sv
// Ethernet stream interface shared by the NAP-facing blocks.
// A beat transfers on every cycle where valid and ready are both high;
// the source holds its beat stable until that happens, and eop marks the
// final beat of a packet.
interface t_ETH_STREAM;
    logic valid;
    logic ready;
    logic eop;

    modport source  (output valid, output eop, input  ready);
    modport sink    (input  valid, input  eop, output ready);
    modport monitor (input  valid, input  ready, input eop);
endinterface

// File: rtl/rx_rate_monitor.sv
// rx_rate_monitor: passive observer of the RX Ethernet stream. Counts
// transferred beats and packets over back-to-back windows of WINDOW_CYCLES
// cycles. At the end of each window it reports the totals and flags windows
// that fall outside [MIN_BEATS, MAX_BEATS]. The first window is aligned to
// the first transfer after monitoring is enabled, so leading idle time is
// not measured.
module rx_rate_monitor #(
    parameter int WINDOW_CYCLES = 1300,
    parameter int MIN_BEATS     = 900,
    parameter int MAX_BEATS     = 1000,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_clear,
    t_ETH_STREAM.monitor     if_eth_mon,
    output logic [CNT_W-1:0] o_beat_count,
    output logic [CNT_W-1:0] o_pkt_count,
    output logic             o_window_done,
    output logic             o_rate_ok,
    output logic             o_under_rate,
    output logic             o_over_rate,
    output logic [1:0]       o_state
);

    // Configuration sanity: thresholds must be ordered and fit the window,
    // and the window length must fit the counter width.
    if (WINDOW_CYCLES < 2 || MIN_BEATS > MAX_BEATS || MAX_BEATS > WINDOW_CYCLES ||
        longint'(WINDOW_CYCLES) >= (longint'(1) << CNT_W)) begin : g_cfg_err
        $error("rx_rate_monitor: illegal configuration WINDOW_CYCLES=%0d MIN_BEATS=%0d MAX_BEATS=%0d CNT_W=%0d",
               WINDOW_CYCLES, MIN_BEATS, MAX_BEATS, CNT_W);
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_B    = CNT_W'(MIN_BEATS);
    localparam logic [CNT_W-1:0] MAX_B    = CNT_W'(MAX_BEATS);

    state_t           state;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] pkt_cnt;

    logic             xfer;
    logic             xfer_eop;
    logic [CNT_W-1:0] beat_nxt;
    logic [CNT_W-1:0] pkt_nxt;
    logic             last_cycle;
    logic             under_hit;
    logic             over_hit;

    // A beat is accepted only when valid and ready coincide; the monitor
    // never drives either signal.
    assign xfer     = if_eth_mon.valid & if_eth_mon.ready;
    assign xfer_eop = xfer & if_eth_mon.eop;

    // Running totals including this cycle's transfer, saturating at all-ones.
    assign beat_nxt = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_W'(xfer);
    assign pkt_nxt  = (pkt_cnt  == CNT_MAX) ? pkt_cnt  : pkt_cnt  + CNT_W'(xfer_eop);

    // The final window cycle's transfer belongs to the ending window, so the
    // thresholds are applied to the totals that include it.
    assign last_cycle = (win_cnt == LAST_CNT);
    assign under_hit  = (beat_nxt < MIN_B);
    assign over_hit   = (beat_nxt > MAX_B);

    assign o_state = state;

    // Window FSM, counters and registered report outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= ST_IDLE;
            win_cnt       <= '0;
            beat_cnt      <= '0;
            pkt_cnt       <= '0;
            o_beat_count  <= '0;
            o_pkt_count   <= '0;
            o_window_done <= 1'b0;
            o_rate_ok     <= 1'b0;
            o_under_rate  <= 1'b0;
            o_over_rate   <= 1'b0;
        end else begin
            o_window_done <= 1'b0;

            // Clear first so that a violating window end on the same cycle
            // re-asserts the flag below.
            if (i_clear) begin
                o_under_rate <= 1'b0;
                o_over_rate  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    if (!i_start) begin
                        state <= ST_IDLE;
                    end else if (xfer) begin
                        state    <= ST_MEASURE;
                        win_cnt  <= CNT_W'(1);
                        beat_cnt <= CNT_W'(1);
                        pkt_cnt  <= CNT_W'(if_eth_mon.eop);
                    end
                end

                ST_MEASURE: begin
                    if (last_cycle) begin
                        // Report and start the next window with no gap.
                        o_beat_count  <= beat_nxt;
                        o_pkt_count   <= pkt_nxt;
                        o_window_done <= 1'b1;
                        o_rate_ok     <= !under_hit && !over_hit;
                        if (under_hit) begin
                            o_under_rate <= 1'b1;
                        end
                        if (over_hit) begin
                            o_over_rate <= 1'b1;
                        end
                        win_cnt  <= '0;
                        beat_cnt <= '0;
                        pkt_cnt  <= '0;
                        if (!i_start) begin
                            state <= ST_IDLE;
                        end
                    end else if (!i_start) begin
                        // Partial window is discarded; outputs keep last report.
                        state    <= ST_IDLE;
                        win_cnt  <= '0;
                        beat_cnt <= '0;
                        pkt_cnt  <= '0;
                    end else begin
                        win_cnt  <= win_cnt + CNT_W'(1);
                        beat_cnt <= beat_nxt;
                        pkt_cnt  <= pkt_nxt;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_rate_monitor.sv
// Testbench for rx_rate_monitor: three instances (default 1300-cycle window,
// an 8-bit 200-cycle window and an 8-bit 255-cycle window) share one stream
// stimulus. A window-level behavioural model predicts every output each cycle,
// and directed literal checks pin the expected window totals.
module tb_rx_rate_monitor;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic start_m;
    logic start_s;
    logic clear;
    logic valid;
    logic ready;
    logic eop;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    t_ETH_STREAM if_m ();
    t_ETH_STREAM if_s8 ();
    t_ETH_STREAM if_s9 ();

    assign if_m.valid  = valid;
    assign if_m.ready  = ready;
    assign if_m.eop    = eop;
    assign if_s8.valid = valid;
    assign if_s8.ready = ready;
    assign if_s8.eop   = eop;
    assign if_s9.valid = valid;
    assign if_s9.ready = ready;
    assign if_s9.eop   = eop;

    logic [15:0] beat_m, pkt_m;
    logic [7:0]  beat_s8, pkt_s8, beat_s9, pkt_s9;
    logic        done_m, ok_m, under_m, over_m;
    logic        done_s8, ok_s8, under_s8, over_s8;
    logic        done_s9, ok_s9, under_s9, over_s9;
    logic [1:0]  state_m, state_s8, state_s9;

    rx_rate_monitor u_dut_m (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_start       (start_m),
        .i_clear       (clear),
        .if_eth_mon    (if_m),
        .o_beat_count  (beat_m),
        .o_pkt_count   (pkt_m),
        .o_window_done (done_m),
        .o_rate_ok     (ok_m),
        .o_under_rate  (under_m),
        .o_over_rate   (over_m),
        .o_state       (state_m)
    );

    rx_rate_monitor #(.WINDOW_CYCLES(200), .MIN_BEATS(150), .MAX_BEATS(200), .CNT_W(8)) u_dut_s8 (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_start       (start_s),
        .i_clear       (clear),
        .if_eth_mon    (if_s8),
        .o_beat_count  (beat_s8),
        .o_pkt_count   (pkt_s8),
        .o_window_done (done_s8),
        .o_rate_ok     (ok_s8),
        .o_under_rate  (under_s8),
        .o_over_rate   (over_s8),
        .o_state       (state_s8)
    );

    rx_rate_monitor #(.WINDOW_CYCLES(255), .MIN_BEATS(200), .MAX_BEATS(255), .CNT_W(8)) u_dut_s9 (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_start       (start_s),
        .i_clear       (clear),
        .if_eth_mon    (if_s9),
        .o_beat_count  (beat_s9),
        .o_pkt_count   (pkt_s9),
        .o_window_done (done_s9),
        .o_rate_ok     (ok_s9),
        .o_under_rate  (under_s9),
        .o_over_rate   (over_s9),
        .o_state       (state_s9)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pos: -2 idle, -1 waiting for the first transfer, >=0 cycles of the
    // current window already counted.
    typedef struct {
        int pos;
        int beats;
        int pkts;
        int beat_o;
        int pkt_o;
        bit done;
        bit ok;
        bit under;
        bit over;
    } mdl_t;

    function automatic mdl_t mdl_next(input mdl_t m, input int win, input int mn, input int mx,
                                      input int satmax, input bit rn, input bit st, input bit clr,
                                      input bit x, input bit e);
        mdl_t n;
        int   b;
        n = m;
        n.done = 1'b0;
        if (!rn) begin
            n.pos = -2; n.beats = 0; n.pkts = 0; n.beat_o = 0; n.pkt_o = 0;
            n.ok = 1'b0; n.under = 1'b0; n.over = 1'b0;
            return n;
        end
        if (clr) begin
            n.under = 1'b0;
            n.over  = 1'b0;
        end
        if (n.pos == -2) begin
            if (st) n.pos = -1;
        end else if (n.pos == -1) begin
            if (!st) n.pos = -2;
            else if (x) begin
                n.pos = 1; n.beats = 1; n.pkts = e ? 1 : 0;
            end
        end else begin
            n.beats += (x ? 1 : 0);
            n.pkts  += ((x && e) ? 1 : 0);
            n.pos   += 1;
            if (n.pos == win) begin
                b = (n.beats > satmax) ? satmax : n.beats;
                n.beat_o = b;
                n.pkt_o  = (n.pkts > satmax) ? satmax : n.pkts;
                n.done   = 1'b1;
                n.ok     = (b >= mn) && (b <= mx);
                if (b < mn) n.under = 1'b1;
                if (b > mx) n.over  = 1'b1;
                n.pos   = st ? 0 : -2;
                n.beats = 0;
                n.pkts  = 0;
            end else if (!st) begin
                n.pos = -2; n.beats = 0; n.pkts = 0;
            end
        end
        return n;
    endfunction

    mdl_t m_m  = '{default: 0};
    mdl_t m_s8 = '{default: 0};
    mdl_t m_s9 = '{default: 0};

    // Model advances on every active edge from the inputs held since the last negedge.
    always @(posedge clk) begin
        m_m  <= mdl_next(m_m,  1300, 900, 1000, 65535, rst_n, start_m, clear, valid & ready, eop);
        m_s8 <= mdl_next(m_s8, 200,  150, 200,  255,   rst_n, start_s, clear, valid & ready, eop);
        m_s9 <= mdl_next(m_s9, 255,  200, 255,  255,   rst_n, start_s, clear, valid & ready, eop);
    end

    task automatic check_dut(input string tag, input mdl_t m, input int beat, input int pkt,
                             input bit done, input bit ok, input bit un, input bit ov);
        check({tag, "_beat"},  beat, m.beat_o);
        check({tag, "_pkt"},   pkt,  m.pkt_o);
        check({tag, "_done"},  int'(done), int'(m.done));
        check({tag, "_ok"},    int'(ok),   int'(m.ok));
        check({tag, "_under"}, int'(un),   int'(m.under));
        check({tag, "_over"},  int'(ov),   int'(m.over));
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        check_dut("m",  m_m,  int'(beat_m),  int'(pkt_m),  done_m,  ok_m,  under_m,  over_m);
        check_dut("s8", m_s8, int'(beat_s8), int'(pkt_s8), done_s8, ok_s8, under_s8, over_s8);
        check_dut("s9", m_s9, int'(beat_s9), int'(pkt_s9), done_s9, ok_s9, under_s9, over_s9);
    end

    // ---------------- driver ----------------
    // mode 0 full rate, 1 = 10 on / 3 off, 2 = 8 on / 5 off,
    // 3 = valid high with ready alternating, 4 = idle.
    int mode     = 4;
    int ph       = 0;
    int cyc      = 0;
    int beat_idx = 0;

    task automatic step();
        case (mode)
            0:       begin valid = 1'b1; ready = 1'b1; end
            1:       begin valid = (ph < 10); ready = (ph < 10); end
            2:       begin valid = (ph < 8);  ready = (ph < 8);  end
            3:       begin valid = 1'b1; ready = (cyc % 2 == 1); end
            default: begin valid = 1'b0; ready = 1'b1; end
        endcase
        eop = valid && (beat_idx % 4 == 3);
        if (valid && ready) beat_idx++;
        ph  = (ph == 12) ? 0 : ph + 1;
        cyc++;
        @(negedge clk);
    endtask

    function automatic bit sel_done(input int which);
        if (which == 0) return done_m;
        if (which == 1) return done_s8;
        return done_s9;
    endfunction

    task automatic wait_done(input int which, input int budget, output int cycles);
        cycles = 0;
        forever begin
            step();
            cycles++;
            if (sel_done(which)) break;
            if (cycles >= budget) begin
                n_checks++;
                n_errors++;
                $display("FAIL wait_done_%0d: actual timeout after %0d cycles required window done", which, cycles);
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    int wcyc;
    int ndone;

    initial begin
        rst_n = 1'b0; start_m = 1'b0; start_s = 1'b0; clear = 1'b0;
        valid = 1'b0; ready = 1'b0; eop = 1'b0;
        repeat (4) step();
        check("rst_beat",  int'(beat_m), 0);
        check("rst_ok",    int'(ok_m), 0);
        check("rst_under", int'(under_m), 0);
        check("rst_done",  int'(done_m), 0);
        rst_n = 1'b1;
        step();

        // 1: full rate -> 1300 beats, over-rate
        start_m = 1'b1; mode = 0;
        wait_done(0, 1400, wcyc);
        wait_done(0, 1400, wcyc);
        check("t1_beat", int'(beat_m), 1300);
        check("t1_pkt",  int'(pkt_m), 325);
        check("t1_over", int'(over_m), 1);
        check("t1_ok",   int'(ok_m), 0);

        // 2: nominal 10/13 pattern after clearing
        start_m = 1'b0; step(); step();
        clear = 1'b1; step(); clear = 1'b0;
        check("t2_cleared", int'(over_m), 0);
        start_m = 1'b1; mode = 1;
        wait_done(0, 1400, wcyc);
        check("t2_beat",  int'(beat_m), 1000);
        check("t2_pkt",   int'(pkt_m), 250);
        check("t2_ok",    int'(ok_m), 1);
        check("t2_under", int'(under_m), 0);
        check("t2_over",  int'(over_m), 0);

        // 3: 8/13 under-rate, then clear and return to 10/13
        mode = 2;
        wait_done(0, 1400, wcyc);
        wait_done(0, 1400, wcyc);
        check("t3_beat",  int'(beat_m), 800);
        check("t3_under", int'(under_m), 1);
        check("t3_ok",    int'(ok_m), 0);
        mode = 1;
        clear = 1'b1; step(); clear = 1'b0;
        check("t3_clear", int'(under_m), 0);
        wait_done(0, 1400, wcyc);
        check("t3_ok2",    int'(ok_m), 1);
        check("t3_under2", int'(under_m), 0);

        // 4: ready alternating -> only transfers count
        mode = 3;
        wait_done(0, 1400, wcyc);
        wait_done(0, 1400, wcyc);
        check("t4_beat",  int'(beat_m), 650);
        check("t4_under", int'(under_m), 1);
        check("t4_ok",    int'(ok_m), 0);

        // 5: start drops mid-window, then re-arm on an idle stream
        repeat (700) step();
        start_m = 1'b0;
        ndone = 0;
        repeat (1000) begin
            step();
            if (done_m) ndone++;
        end
        check("t5_no_done", ndone, 0);
        check("t5_hold",    int'(beat_m), 650);
        start_m = 1'b1; mode = 4;
        repeat (50) step();
        mode = 0;
        wait_done(0, 1400, wcyc);
        check("t5_align", wcyc, 1300);
        check("t5_beat",  int'(beat_m), 1300);

        // 6: narrow counters at full rate, reset mid-window
        start_m = 1'b0; start_s = 1'b1; mode = 0;
        repeat (460) step();
        check("t6_s8_beat", int'(beat_s8), 200);
        check("t6_s8_ok",   int'(ok_s8), 1);
        check("t6_s9_beat", int'(beat_s9), 255);
        check("t6_s9_ok",   int'(ok_s9), 1);
        check("t6_s9_over", int'(over_s9), 0);
        repeat (40) step();
        rst_n = 1'b0; step(); step();
        check("t6_rst_m_beat",   int'(beat_m), 0);
        check("t6_rst_m_under",  int'(under_m), 0);
        check("t6_rst_m_over",   int'(over_m), 0);
        check("t6_rst_s8_beat",  int'(beat_s8), 0);
        check("t6_rst_s8_ok",    int'(ok_s8), 0);
        check("t6_rst_s9_beat",  int'(beat_s9), 0);
        check("t6_rst_s9_pkt",   int'(pkt_s9), 0);
        rst_n = 1'b1;
        wait_done(1, 300, wcyc);
        check("t6_s8_beat2", int'(beat_s8), 200);
        check("t6_s8_pkt2",  int'(pkt_s8), 50);
        check("t6_s8_ok2",   int'(ok_s8), 1);
        wait_done(2, 300, wcyc);
        check("t6_s9_beat2", int'(beat_s9), 255);
        check("t6_s9_ok2",   int'(ok_s9), 1);
        check("t6_s9_over2", int'(over_s9), 0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
